// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ram_rr_arbiter                                             |
// | Description : Round-robin arbiter sharing one single-port RAM between    |
// |               two REQ/ACK requesters (A and B). Every transaction is     |
// |               IDLE -> ISSUE -> READ -> RESP, and all outputs are          |
// |               registered.                                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ram_rr_arbiter #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 8
) (
  input  logic              CLK_,
  input  logic              RST_,
  input  logic              REQ_A,
  input  logic              WE_A,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [DATA_W-1:0] WDATA_A,
  output logic              GNT_A,
  output logic              ACK_A,
  output logic [DATA_W-1:0] RDATA_A,
  input  logic              REQ_B,
  input  logic              WE_B,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] WDATA_B,
  output logic              GNT_B,
  output logic              ACK_B,
  output logic [DATA_W-1:0] RDATA_B,
  output logic              RAM_RW_,
  output logic [ADDR_W-1:0] RAM_ADDR_,
  output logic [DATA_W-1:0] RAM_DATA_IN,
  input  logic [DATA_W-1:0] RAM_DATA_OUT,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic                r_last_b,   w_last_b_nxt;   // 1: B was served last
  logic                r_sel_b,    w_sel_b_nxt;    // owner of the current transaction
  logic                r_we,       w_we_nxt;       // kept past ISSUE, when RAM_RW_ is already low
  logic                r_gnt_a,    w_gnt_a_nxt;
  logic                r_gnt_b,    w_gnt_b_nxt;
  logic                r_ack_a,    w_ack_a_nxt;
  logic                r_ack_b,    w_ack_b_nxt;
  logic [DATA_W-1:0]   r_rdata_a,  w_rdata_a_nxt;
  logic [DATA_W-1:0]   r_rdata_b,  w_rdata_b_nxt;
  logic                r_ram_rw,   w_ram_rw_nxt;
  logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_nxt;
  logic [DATA_W-1:0]   r_ram_din,  w_ram_din_nxt;
  logic                r_busy,     w_busy_nxt;

  logic                w_grant_a;
  logic                w_grant_b;

  // A wins when alone or when B was served last; otherwise B wins if it asks.
  assign w_grant_a = REQ_A && (!REQ_B || r_last_b);
  assign w_grant_b = REQ_B && !w_grant_a;

  // Next-state and next-output logic; every register holds unless a state changes it.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_b_nxt   = r_last_b;
    w_sel_b_nxt    = r_sel_b;
    w_we_nxt       = r_we;
    w_gnt_a_nxt    = r_gnt_a;
    w_gnt_b_nxt    = r_gnt_b;
    w_ack_a_nxt    = r_ack_a;
    w_ack_b_nxt    = r_ack_b;
    w_rdata_a_nxt  = r_rdata_a;
    w_rdata_b_nxt  = r_rdata_b;
    w_ram_rw_nxt   = r_ram_rw;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_din_nxt  = r_ram_din;

    case (r_state)
      S_IDLE: begin
        w_ram_rw_nxt = 1'b0;
        if (w_grant_a) begin
          w_sel_b_nxt    = 1'b0;
          w_we_nxt       = WE_A;
          w_ram_rw_nxt   = WE_A;
          w_ram_addr_nxt = ADDR_A;
          w_ram_din_nxt  = WDATA_A;
          w_gnt_a_nxt    = 1'b1;
          w_state_nxt    = S_ISSUE;
        end else if (w_grant_b) begin
          w_sel_b_nxt    = 1'b1;
          w_we_nxt       = WE_B;
          w_ram_rw_nxt   = WE_B;
          w_ram_addr_nxt = ADDR_B;
          w_ram_din_nxt  = WDATA_B;
          w_gnt_b_nxt    = 1'b1;
          w_state_nxt    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // The RAM commits the command on this edge; a write pulse lasts one cycle.
        w_ram_rw_nxt = 1'b0;
        w_state_nxt  = S_READ;
      end

      S_READ: begin
        if (!r_we) begin
          if (r_sel_b) w_rdata_b_nxt = RAM_DATA_OUT;
          else         w_rdata_a_nxt = RAM_DATA_OUT;
        end
        if (r_sel_b) w_ack_b_nxt = 1'b1;
        else         w_ack_a_nxt = 1'b1;
        w_state_nxt = S_RESP;
      end

      S_RESP: begin
        w_ack_a_nxt  = 1'b0;
        w_ack_b_nxt  = 1'b0;
        w_gnt_a_nxt  = 1'b0;
        w_gnt_b_nxt  = 1'b0;
        w_last_b_nxt = r_sel_b;
        w_state_nxt  = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers with synchronous reset that drops any transaction.
  always_ff @(posedge CLK_) begin
    if (RST_) begin
      r_state    <= S_IDLE;
      r_last_b   <= 1'b1;
      r_sel_b    <= 1'b0;
      r_we       <= 1'b0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_ram_rw   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_b   <= w_last_b_nxt;
      r_sel_b    <= w_sel_b_nxt;
      r_we       <= w_we_nxt;
      r_gnt_a    <= w_gnt_a_nxt;
      r_gnt_b    <= w_gnt_b_nxt;
      r_ack_a    <= w_ack_a_nxt;
      r_ack_b    <= w_ack_b_nxt;
      r_rdata_a  <= w_rdata_a_nxt;
      r_rdata_b  <= w_rdata_b_nxt;
      r_ram_rw   <= w_ram_rw_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_din  <= w_ram_din_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign GNT_A       = r_gnt_a;
  assign GNT_B       = r_gnt_b;
  assign ACK_A       = r_ack_a;
  assign ACK_B       = r_ack_b;
  assign RDATA_A     = r_rdata_a;
  assign RDATA_B     = r_rdata_b;
  assign RAM_RW_     = r_ram_rw;
  assign RAM_ADDR_   = r_ram_addr;
  assign RAM_DATA_IN = r_ram_din;
  assign BUSY        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ram_rr_arbiter                                          |
// | Description : Directed self-checking bench for ram_rr_arbiter, with a    |
// |               small behavioural single-port RAM attached.                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ram_rr_arbiter;

  localparam int C_ADDR_W = 1;
  localparam int C_DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_a, we_a, req_b, we_b;
  logic [C_ADDR_W-1:0] addr_a, addr_b;
  logic [C_DATA_W-1:0] wdata_a, wdata_b;
  logic                gnt_a, ack_a, gnt_b, ack_b;
  logic [C_DATA_W-1:0] rdata_a, rdata_b;
  logic                ram_rw;
  logic [C_ADDR_W-1:0] ram_addr;
  logic [C_DATA_W-1:0] ram_din;
  logic [C_DATA_W-1:0] ram_dout;
  logic                busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [C_DATA_W-1:0] mem [2] = '{8'h00, 8'h00};

  always #5 clk = ~clk;

  ram_rr_arbiter #(.ADDR_W(C_ADDR_W), .DATA_W(C_DATA_W)) u_dut (
    .CLK_        (clk),
    .RST_        (rst),
    .REQ_A       (req_a),
    .WE_A        (we_a),
    .ADDR_A      (addr_a),
    .WDATA_A     (wdata_a),
    .GNT_A       (gnt_a),
    .ACK_A       (ack_a),
    .RDATA_A     (rdata_a),
    .REQ_B       (req_b),
    .WE_B        (we_b),
    .ADDR_B      (addr_b),
    .WDATA_B     (wdata_b),
    .GNT_B       (gnt_b),
    .ACK_B       (ack_b),
    .RDATA_B     (rdata_b),
    .RAM_RW_     (ram_rw),
    .RAM_ADDR_   (ram_addr),
    .RAM_DATA_IN (ram_din),
    .RAM_DATA_OUT(ram_dout),
    .BUSY        (busy)
  );

  // Single-port RAM: the command edge writes and launches read data for the next cycle.
  always_ff @(posedge clk) begin
    if (ram_rw) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction from IDLE for one requester, checked cycle by cycle.
  task automatic run_txn(input bit is_b, input bit we, input logic [C_ADDR_W-1:0] addr,
                         input logic [C_DATA_W-1:0] wd, input logic [C_DATA_W-1:0] exp_rd,
                         input logic [C_DATA_W-1:0] other_rd);
    if (is_b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
    else      begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
    tick();  // grant edge -> ISSUE
    check_val("issue_gnt_own",   32'(is_b ? gnt_b : gnt_a), 32'd1);
    check_val("issue_gnt_other", 32'(is_b ? gnt_a : gnt_b), 32'd0);
    check_val("issue_busy",      32'(busy), 32'd1);
    check_val("issue_ram_rw",    32'(ram_rw), 32'(we));
    check_val("issue_ram_addr",  32'(ram_addr), 32'(addr));
    check_val("issue_ram_din",   32'(ram_din), 32'(wd));
    tick();  // READ
    check_val("read_ram_rw",     32'(ram_rw), 32'd0);
    check_val("read_ack_own",    32'(is_b ? ack_b : ack_a), 32'd0);
    tick();  // RESP
    check_val("resp_ack_own",    32'(is_b ? ack_b : ack_a), 32'd1);
    check_val("resp_ack_other",  32'(is_b ? ack_a : ack_b), 32'd0);
    check_val("resp_rdata_own",  32'(is_b ? rdata_b : rdata_a), 32'(exp_rd));
    check_val("resp_rdata_other",32'(is_b ? rdata_a : rdata_b), 32'(other_rd));
    if (is_b) req_b = 1'b0; else req_a = 1'b0;
    tick();  // back in IDLE
    check_val("idle_gnt_own",    32'(is_b ? gnt_b : gnt_a), 32'd0);
    check_val("idle_ack_own",    32'(is_b ? ack_b : ack_a), 32'd0);
    check_val("idle_busy",       32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;

    // Reset state
    do_reset();
    check_val("rst_gnt_a",   32'(gnt_a), 32'd0);
    check_val("rst_gnt_b",   32'(gnt_b), 32'd0);
    check_val("rst_ack_a",   32'(ack_a), 32'd0);
    check_val("rst_ack_b",   32'(ack_b), 32'd0);
    check_val("rst_busy",    32'(busy), 32'd0);
    check_val("rst_ram_rw",  32'(ram_rw), 32'd0);
    check_val("rst_ram_addr",32'(ram_addr), 32'd0);
    check_val("rst_ram_din", 32'(ram_din), 32'd0);
    check_val("rst_rdata_a", 32'(rdata_a), 32'd0);
    check_val("rst_rdata_b", 32'(rdata_b), 32'd0);

    // A writes AA to addr 0, then reads it back
    run_txn(1'b0, 1'b1, 1'b0, 8'hAA, 8'h00, 8'h00);
    run_txn(1'b0, 1'b0, 1'b0, 8'h00, 8'hAA, 8'h00);
    check_val("after_a_gnt_b", 32'(gnt_b), 32'd0);

    // B writes CC to addr 1, then A reads addr 1
    run_txn(1'b1, 1'b1, 1'b1, 8'hCC, 8'h00, 8'hAA);
    run_txn(1'b0, 1'b0, 1'b1, 8'h00, 8'hCC, 8'h00);

    // Tie after reset: both held for four reads, grants must alternate A,B,A,B
    do_reset();
    we_a = 1'b0; addr_a = 1'b0;
    we_b = 1'b0; addr_b = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();  // ISSUE
      check_val("tie_gnt_a", 32'(gnt_a), 32'((k % 2) == 0));
      check_val("tie_gnt_b", 32'(gnt_b), 32'((k % 2) == 1));
      tick();
      tick();  // RESP, 2 cycles after ISSUE -> ACKs spaced 4 cycles apart
      if ((k % 2) == 0) begin
        check_val("tie_ack_a",   32'(ack_a), 32'd1);
        check_val("tie_rdata_a", 32'(rdata_a), 32'h0000_00AA);
      end else begin
        check_val("tie_ack_b",   32'(ack_b), 32'd1);
        check_val("tie_rdata_b", 32'(rdata_b), 32'h0000_00CC);
      end
      if (k == 3) begin req_a = 1'b0; req_b = 1'b0; end
      tick();  // IDLE
    end
    check_val("tie_end_busy", 32'(busy), 32'd0);

    // Leave LAST = A, then reset during the READ of an A read
    run_txn(1'b0, 1'b0, 1'b0, 8'h00, 8'hAA, 8'hCC);
    req_a = 1'b1; we_a = 1'b0; addr_a = 1'b1;
    tick();  // ISSUE
    tick();  // READ
    rst = 1'b1;
    req_a = 1'b0;
    tick();
    rst = 1'b0;
    check_val("midrst_gnt_a",   32'(gnt_a), 32'd0);
    check_val("midrst_ack_a",   32'(ack_a), 32'd0);
    check_val("midrst_busy",    32'(busy), 32'd0);
    check_val("midrst_rdata_a", 32'(rdata_a), 32'd0);
    tick();
    tick();
    check_val("midrst_no_ack_a", 32'(ack_a), 32'd0);

    // The next tie must go to A since reset restores LAST = B
    req_a = 1'b1; req_b = 1'b1;
    tick();
    check_val("post_rst_tie_gnt_a", 32'(gnt_a), 32'd1);
    check_val("post_rst_tie_gnt_b", 32'(gnt_b), 32'd0);
    tick();
    tick();
    req_a = 1'b0; req_b = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
